cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry look-ahead adder. It generalises the fixed 8-bit combinational CLA to any WIDTH built from BLOCK-bit look-ahead groups, with one register stage per group. A valid/ready handshake on input and output supports full throughput and backpressure. It is the arithmetic building block for wide counters and accumulators in the FPGA designs.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_group.sv | 40 ++++
 rtl/cla_pipe_adder.sv | 74 +++++++
 tb/tb_cla_pipe_adder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared group generate/propagate helper and pipeline stage record for cla_pipe_adder.
package cla_pkg;
  localparam int CLA_BLOCK = 4;
  localparam int CLA_MAX_BLOCK = 16;
  localparam int CLA_MAX_W = 64;
  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CLA_MAX_W-1:0] sum;
    logic [CLA_MAX_W-1:0] ra;
    logic [CLA_MAX_W-1:0] rb;
  } cla_stage_t;
  function automatic cla_gp_t cla_gp(input logic [CLA_MAX_BLOCK-1:0] a, input logic [CLA_MAX_BLOCK-1:0] b, input int n);
    cla_gp_t r;
    r = '{g: 1'b0, p: 1'b1};
    for (int i = 0; i < CLA_MAX_BLOCK; i++)
      if (i < n) begin
        r.g = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.g);
        r.p = r.p & (a[i] ^ b[i]);
      end
    return r;
  endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational BLOCK-bit carry look-ahead group with fully expanded internal carries.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             g,
  output logic             p
);
  logic [BLOCK-1:0] gv, pv, c;
  logic t;
  cla_gp_t gp;
  assign gv = a & b;
  assign pv = a ^ b;
  assign gp = cla_gp(CLA_MAX_BLOCK'(a), CLA_MAX_BLOCK'(b), BLOCK);
  assign g  = gp.g;
  assign p  = gp.p;
  assign co = g | (p & ci);
  // each c[i] is a flat sum of products over ci, g and p: no carry chain
  always_comb begin
    c = '0;
    t = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      t = ci;
      for (int j = 0; j < i; j++) t = t & pv[j];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = gv[j];
        for (int m = j + 1; m < i; m++) t = t & pv[m];
        c[i] = c[i] | t;
      end
    end
  end
  assign s = pv ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA adder, one register stage per BLOCK-bit group, valid/ready handshake.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NG = WIDTH / BLOCK;
  logic advance;
  if (WIDTH % BLOCK != 0 || WIDTH < BLOCK || WIDTH > CLA_MAX_W || BLOCK > CLA_MAX_BLOCK) begin : bad_cfg
    $error("cla_pipe_adder: unsupported WIDTH/BLOCK");
  end
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  genvar k;
  for (k = 0; k < NG; k++) begin : st
    cla_stage_t src, r;
    logic [BLOCK-1:0] s;
    logic co, gg, pp;
    if (k == 0) begin : head
      assign src = '{valid: in_valid, carry: cin, sum: '0, ra: CLA_MAX_W'(a), rb: CLA_MAX_W'(b)};
    end else begin : link
      assign src = st[k-1].r;
    end
    cla_group #(.BLOCK(BLOCK)) grp (
      .a (src.ra[BLOCK-1:0]),
      .b (src.rb[BLOCK-1:0]),
      .ci(src.carry),
      .s (s),
      .co(co),
      .g (gg),
      .p (pp)
    );
    // operands shift down so every stage consumes the low BLOCK bits
    always_ff @(posedge clk or posedge rst)
      if (rst) r <= '0;
      else if (advance) begin
        r.valid <= src.valid;
        r.carry <= co;
        r.sum   <= src.sum | (CLA_MAX_W'(s) << (k * BLOCK));
        r.ra    <= src.ra >> BLOCK;
        r.rb    <= src.rb >> BLOCK;
      end
    always_comb assert (co == (gg | (pp & src.carry)));
  end
  assign out_valid = st[NG-1].r.valid;
  assign sum       = st[NG-1].r.sum[WIDTH-1:0];
  assign cout      = st[NG-1].r.carry;
  // every operand bit has been consumed and nothing lands above WIDTH
  always_comb assert (!(|{st[NG-1].r.ra, st[NG-1].r.rb, st[NG-1].r.sum >> WIDTH}));
`ifdef CLA_PIPE_OVF_EN
  // carry into the MSB is p ^ s at that bit
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (advance) ovf <= st[NG-1].src.ra[BLOCK-1] ^ st[NG-1].src.rb[BLOCK-1] ^ st[NG-1].s[BLOCK-1] ^ st[NG-1].co;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: random and directed stimulus against a queue-based arithmetic model.
// Define CLA_PIPE_OVF_EN to also check the overflow output.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0, cout;
  logic [15:0] a = '0, b = '0, sum;
  logic ovf;
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, outs = 0, ins = 0, first_out = -1, last_out = -1, n;
  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef CLA_PIPE_OVF_EN
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic ordy);
    exp_t e;
    logic [16:0] t;
    @(negedge clk);
    in_valid = v; a = xa; b = xb; cin = xc; out_ready = ordy;
    #1;
    cyc++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 32'(out_valid), 0);
      else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
`ifdef CLA_PIPE_OVF_EN
        check("ovf", 32'(ovf), 32'(e.o));
`endif
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (in_valid && in_ready) begin
      t = 17'(xa) + 17'(xb) + 17'(xc);
      e.s = t[15:0];
      e.c = t[16];
      e.o = (xa[15] == xb[15]) && (t[15] != xa[15]);
      q.push_back(e);
      ins++;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step(0, 16'h0, 16'h0, 0, 1);
    check("drain_empty", 32'(q.size()), 0);
    check("in_out_count", 32'(outs), 32'(ins));
  endtask
  task automatic clear_counts();
    outs = 0; ins = 0; first_out = -1; last_out = -1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    // latency of a single pair
    step(1, 16'd56, 16'd38, 0, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 16'h0, 16'h0, 0, 1);
      n++;
      if (out_valid) begin
        check("lat_sum", 32'(sum), 94);
        check("lat_cout", 32'(cout), 0);
        break;
      end
    end
    check("latency", 32'(n), 4);
    clear_counts();
    q.delete();
    // carry across group boundaries
    step(1, 16'hFFFF, 16'h0001, 0, 1);
    step(1, 16'h00FF, 16'h0001, 0, 1);
    step(1, 16'h0FFF, 16'h0000, 1, 1);
    step(1, 16'hFFFF, 16'hFFFF, 1, 1);
`ifdef CLA_PIPE_OVF_EN
    step(1, 16'h7FFF, 16'h0001, 0, 1);
    step(1, 16'h8000, 16'h8000, 0, 1);
    step(1, 16'h4000, 16'h3FFF, 1, 1);
`endif
    drain();
    // back-to-back stream
    clear_counts();
    for (int i = 0; i < 100; i++) step(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
    drain();
    check("stream_count", 32'(outs), 100);
    check("stream_consecutive", 32'(last_out - first_out + 1), 100);
    // stall with a full pipeline
    clear_counts();
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 16'($urandom), 16'($urandom), 1'($urandom), 0);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_valid", 32'(out_valid), 1);
      if (q.size() > 0) begin
        check("stall_sum", 32'(sum), 32'(q[0].s));
        check("stall_cout", 32'(cout), 32'(q[0].c));
      end
    end
    drain();
    // asynchronous reset with results in flight
    clear_counts();
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
    step(0, 16'h0, 16'h0, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_in_ready", 32'(in_ready), 1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 16'h0, 16'h0, 0, 1);
      check("no_stale", 32'(out_valid), 0);
    end
    clear_counts();
    step(1, 16'h1234, 16'h4321, 1, 1);
    drain();
    // random traffic with backpressure
    clear_counts();
    for (int i = 0; i < 300; i++)
      step(1'($urandom % 4 != 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom % 3 != 0));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
